// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel arbitrated, registered multiplexer.
// Each cycle at most one requesting channel is granted (round-robin from ptr,
// or lowest index in fixed-priority mode). Its word is captured into a single
// output register with a valid/ready handshake towards the consumer.
module rr_mux_reg #(
  parameter int N     = 4,
  parameter int WIDTH = 64,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic             xfer;

  assign load_en = !out_valid_q || out_ready;

  // Arbitration: pick the first requester, starting at ptr (round-robin) or at 0 (priority).
  // Scanning downward and overwriting leaves the candidate closest to the start point.
  always_comb begin
    int start;
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    start     = mode ? 0 : int'(ptr_q);
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (in_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SELW'(idx);
      end
    end
  end

  // Accept strobes: only the granted channel, only when the output register can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_vld) in_ready[grant_idx] = 1'b1;
  end

  assign xfer = rst_n && load_en && grant_vld;

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_d  = grant_idx;
        if (!mode) begin
          // Wrap at N, not at 2^SELW, so non-power-of-two N stays in range.
          ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg: scoreboard against a behavioural arbitration model,
// plus a small N=3 / WIDTH=8 instance exercising non-power-of-two wrap.
module tb_rr_mux_reg;
  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;

  logic [23:0]    d3;
  logic [2:0]     v3;
  logic [2:0]     r3;
  logic [7:0]     od3;
  logic [1:0]     os3;
  logic           ov3;
  logic           or3 = 1'b1;
  logic           mode3 = 1'b0;

  rr_mux_reg #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_reg #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3),
    .in_data(d3), .in_valid(v3), .in_ready(r3),
    .out_data(od3), .out_sel(os3), .out_valid(ov3),
    .out_ready(or3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the grant is the first requester met when walking the
  // channels circularly from the start point (ptr for round-robin, 0 for priority).
  function automatic int arb(input logic [N-1:0] v, input logic m, input int p);
    int start = m ? 0 : p;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } word_t;

  word_t        sbq[$];
  int           m_ptr = 0;
  bit           m_valid = 1'b0;
  logic [N-1:0] acc_mask = '0;

  // Model: predicts in_ready / out_valid and pushes each accepted word.
  always @(negedge clk) begin
    logic [N-1:0] exp_r;
    int g;
    bit le;
    exp_r = '0;
    g     = -1;
    le    = !m_valid || out_ready;
    if (rst_n && le) g = arb(in_valid, mode, m_ptr);
    if (g >= 0) exp_r[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_r));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    acc_mask = exp_r;
    if (!rst_n) begin
      m_ptr   = 0;
      m_valid = 1'b0;
      sbq.delete();
    end else if (le) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        sbq.push_back('{in_data[g*W +: W], g});
        if (!mode) m_ptr = (g + 1) % N;
      end
    end
  end

  // Monitor: each output handshake pops the oldest expected word.
  always @(negedge clk) begin
    word_t w;
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual sel=%0d data=%0h required none", out_sel, out_data);
      end else begin
        w = sbq.pop_front();
        chk("out_data", out_data, w.d);
        chk("out_sel", 64'(out_sel), 64'(w.s));
      end
    end
  end

  // N=3 instance: all channels request, round-robin, consumer always ready.
  initial begin
    v3 = 3'b111;
    d3 = {8'hA2, 8'hA1, 8'hA0};
    @(posedge rst_n);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("n3_out_valid", 64'(ov3), 64'd1);
      chk("n3_out_sel", 64'(os3), 64'(k % 3));
      chk("n3_out_data", 64'(od3), 64'(8'hA0 + (k % 3)));
      chk("n3_in_ready", 64'(r3), 64'(3'b001 << ((k + 1) % 3)));
    end
  end

  task automatic set_all_index_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'(i);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = '0;
    in_data  = '0;
    step(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // Round-robin over all channels.
    set_all_index_data();
    in_valid  = '1;
    out_ready = 1'b1;
    mode      = 1'b0;
    rst_n     = 1'b1;
    step(10);

    // Fixed priority: channel 0 always wins.
    mode = 1'b1;
    step(8);

    // Backpressure then release.
    mode      = 1'b0;
    out_ready = 1'b0;
    step(6);
    out_ready = 1'b1;
    step(4);

    // Sparse requests with wrap, then idle.
    in_valid = 4'b0011;
    step(5);
    in_valid = 4'b0000;
    step(3);

    // Reset while streaming.
    in_valid = '1;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_sel", 64'(out_sel), 64'd0);
    rst_n = 1'b1;
    step(4);

    // Randomized traffic; producers hold words until the model says accepted.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom % 3) != 0;
          if (in_valid[i]) in_data[i*W +: W] = {$urandom, $urandom};
        end
      end
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 16 == 0) mode = ~mode;
      rst_n = ($urandom % 200) != 0;
      step(1);
    end

    // Drain.
    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    step(4);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
